// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore main FSM, combinational ALU decoder and PC-enable logic.
// Outputs decode the current state in the same cycle (pcen also follows zero); no backpressure, one state per clock.
module mips_multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    state_t r_state;
    state_t w_next;
    aluop_t w_aluop;
    logic   w_pcwrite;
    logic   w_branch;
    logic   w_irwrite;
    logic   w_regwrite;
    logic   w_memwrite;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_aluop    = ALUOP_ADD;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_next    = S_DECODE;
                alusrcb   = 2'b01;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
            end
            S_DECODE: begin
                // Branch target is computed here so BEQEX only has to compare.
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (opcode)
                    OP_LW:   w_next = S_MEMRD;
                    OP_SW:   w_next = S_MEMWR;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                w_next  = S_RTYPEWB;
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                w_aluop  = ALUOP_SUB;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEX: begin
                w_next  = S_ADDIWB;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (w_aluop)
            ALUOP_SUB: alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Enables are gated by reset directly so writes stop the instant reset asserts.
    assign pcen     = reset & (w_pcwrite | (w_branch & zero));
    assign irwrite  = reset & w_irwrite;
    assign regwrite = reset & w_regwrite;
    assign memwrite = reset & w_memwrite;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: directed instructions plus random instruction stream
// compared cycle by cycle against an instruction-level model of the control outputs.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int n_checks = 0;
    int n_pass   = 0;

    // {pcen,irwrite,regwrite,memwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
    localparam logic [14:0] RESET_VEC = {8'b0000_0000, 2'b01, 2'b00, 3'b010};

    mips_multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .pcen      (pcen),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .memwrite  (memwrite),
        .alusrca   (alusrca),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .alucontrol(alucontrol)
    );

    always #5 clk = ~clk;

    logic [14:0] w_obs;
    assign w_obs = {pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
                    alusrcb, pcsrc, alucontrol};

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    function automatic int cpi(input logic [5:0] op);
        case (op)
            6'h23:                      return 5;
            6'h2B, 6'h00, 6'h08:        return 4;
            6'h04, 6'h02:               return 3;
            default:                    return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction, organised per instruction.
    function automatic logic [14:0] model(input logic [5:0] op, input logic [5:0] fn,
                                          input int k, input logic z);
        logic pe, ir, rw, mw, sa, io, mr, rd;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {pe, ir, rw, mw, sa, io, mr, rd} = 8'b0;
        sb = 2'b00;
        ps = 2'b00;
        ac = 3'b010;
        if (k == 0) begin
            pe = 1'b1; ir = 1'b1; sb = 2'b01;
        end else if (k == 1) begin
            sb = 2'b11;
        end else begin
            case (op)
                6'h23: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                       else if (k == 3) io = 1'b1;
                       else begin mr = 1'b1; rw = 1'b1; end
                6'h2B: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                       else begin io = 1'b1; mw = 1'b1; end
                6'h00: if (k == 2) begin sa = 1'b1; ac = alu_of_funct(fn); end
                       else begin rd = 1'b1; rw = 1'b1; end
                6'h04: begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
                6'h08: if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                       else rw = 1'b1;
                6'h02: begin ps = 2'b10; pe = 1'b1; end
                default: ;
            endcase
        end
        return {pe, ir, rw, mw, sa, io, mr, rd, sb, ps, ac};
    endfunction

    // Entered just after a rising edge with the FSM in FETCH; zmode 0/1 fixes zero, 2 randomises.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        opcode = op;
        funct  = fn;
        for (int k = 0; k < cpi(op); k++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            @(negedge clk);
            chk($sformatf("op%02h fn%02h cyc%0d", op, fn, k), w_obs, model(op, fn, k, zero));
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] ops [7];
    logic [5:0] fns [6];

    initial begin
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

        reset  = 1'b0;
        opcode = 6'h23;
        funct  = 6'h00;
        zero   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset hold", w_obs, RESET_VEC);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("release fetch", w_obs, model(6'h23, 6'h00, 0, zero));

        run_instr(6'h23, 6'h00, 2);
        run_instr(6'h2B, 6'h00, 2);
        for (int i = 0; i < 6; i++) run_instr(6'h00, fns[i], 2);
        run_instr(6'h04, 6'h00, 1);
        run_instr(6'h04, 6'h00, 0);
        run_instr(6'h08, 6'h00, 2);
        run_instr(6'h02, 6'h00, 2);
        run_instr(6'h3F, 6'h00, 2);

        // Abort an lw in MEMRD: no writeback may follow.
        opcode = 6'h23;
        zero   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("lw abort cyc%0d", k), w_obs, model(6'h23, 6'h00, k, zero));
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        chk("async reset in memrd", w_obs, RESET_VEC);
        @(posedge clk);
        #1;
        chk("reset after edge", w_obs, RESET_VEC);
        @(negedge clk);
        chk("reset low phase", w_obs, RESET_VEC);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(6'h2B, 6'h00, 2);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op, fn;
            int sel;
            sel = int'($urandom_range(0, 6));
            op  = (sel == 6) ? 6'($urandom_range(0, 63)) : ops[sel];
            fn  = ($urandom_range(0, 1) == 0) ? fns[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 2);
        end

        @(negedge clk);
        chk("final fetch", w_obs, model(6'h00, 6'h00, 0, zero));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Control unit for the multicycle MIPS processor. It consumes opcode, funct and zero from the multicycle datapath. It drives every datapath enable and mux select, plus the memory write strobe. It is a Moore main FSM with a combinational ALU decoder and branch/PC-enable logic, and it sits beside the datapath inside the mips top level.

Parameters:
None. Encodings are fixed by mips_decls_p.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  instr[31:26] (mips_decls_p::opcode_t)
funct  in  6  instr[5:0] (mips_decls_p::funct_t)
zero  in  1  ALU zero flag, combinational from datapath ALU
pcen  out  1  PC register enable
irwrite  out  1  instruction register enable
regwrite  out  1  register file write enable
memwrite  out  1  memory write strobe
alusrca  out  1  0 = PC, 1 = A register
iord  out  1  0 = PC address, 1 = ALUOut address
memtoreg  out  1  0 = ALUOut, 1 = MDR to register file
regdst  out  1  0 = rt, 1 = rd
alusrcb  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  out  3  ALU function

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX. The state register is the only sequential element.
- Reset: asynchronous on reset=0, state <= FETCH.
  - While reset=0, pcen, irwrite, regwrite and memwrite are forced to 0.
  - All selects take their FETCH values while reset=0.
  - The first rising edge after release executes FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw/sw -> MEMADR; R-type (000000) -> RTYPEEX; beq (000100) -> BEQEX; addi (001000) -> ADDIEX; j (000010) -> JEX; any other opcode -> FETCH (treated as a no-op; the PC has already advanced).
  - MEMADR: lw (100011) -> MEMRD; sw (101011) -> MEMWR.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX -> FETCH.
- Per-state outputs. Any signal not listed is 0 and any select not listed is 00.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=add (precomputes the branch target into ALUOut).
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=add.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=funct.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
  - BEQEX: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero). This is combinational, so zero must propagate to pcen within the same cycle.
- ALU decoder (combinational):
  - aluop add -> alucontrol 010; aluop sub -> 110.
  - aluop funct: add 0x20 -> 010, sub 0x22 -> 110, and 0x24 -> 000, or 0x25 -> 001, slt 0x2A -> 111; any other funct -> 010.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- Reset asserted mid-instruction: the in-flight instruction is abandoned and memwrite/regwrite drop immediately (asynchronously). No partial writeback occurs after reset.
- No output may be X after reset. All case statements carry defaults to FETCH or to all-zero outputs.

Test Plan:
- Reset: hold reset=0 for 3 cycles with opcode=0x23 -> pcen=irwrite=regwrite=memwrite=0 and alusrcb=01. Release reset -> first cycle FETCH with irwrite=1, pcen=1, alucontrol=010.
- lw (opcode 0x23): states run FETCH, DECODE, MEMADR, MEMRD, MEMWB. Required: regwrite=1 with memtoreg=1, regdst=0 on cycle 5 only; iord=1 on cycles 4 and 5 only is wrong, iord=1 on MEMRD only; memwrite stays 0 throughout.
- sw (0x2B): exactly one memwrite=1 cycle, in cycle 4, with iord=1. regwrite=0 throughout, and the next cycle is FETCH.
- R-type sweep, opcode 0 with funct 0x20/0x22/0x24/0x25/0x2A/0x00: alucontrol in RTYPEEX is 010/110/000/001/111/010. RTYPEWB gives regdst=1, regwrite=1.
- beq (0x04): zero=1 in BEQEX -> pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 -> pcen=0. Both cases return to FETCH after 3 cycles.
- j (0x02) -> JEX has pcsrc=10, pcen=1. Opcode 0x3F -> DECODE then FETCH with no regwrite or memwrite. Asserting reset during MEMRD -> state FETCH at once and no MEMWB regwrite occurs.
